// File: rtl/bf_array_pkg.sv
// Shared types and defaults for the array tile: FSM states, operand-width
// type, default accumulator/lane widths and the operand extension helper.
package bf_array_pkg;

  localparam int unsigned ACC_WIDTH_DEF = 64;
  localparam int unsigned COL_WIDTH_DEF = 13;

  typedef logic [3:0] opw_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    STREAM,
    DRAIN,
    OUT
  } state_e;

  // Widen an 8-bit raw operand to 9-bit signed, keeping only the low 'width'
  // bits (0 or >8 means all 8) and sign- or zero-extending from the top kept bit.
  function automatic logic signed [8:0] ext_operand(input logic [7:0] raw,
                                                    input opw_t       width,
                                                    input logic       is_signed);
    logic [8:0]  r;
    int unsigned eff;
    logic [2:0]  msb;
    eff = (width == 4'd0 || width > 4'd8) ? 32'd8 : 32'(width);
    msb = 3'(eff - 1);
    for (int unsigned b = 0; b < 9; b++) begin
      r[b] = (b < eff) ? raw[b[2:0]] : (is_signed & raw[msb]);
    end
    return $signed(r);
  endfunction

endpackage

// File: rtl/psum_accum.sv
// N-column accumulator bank: sign-extends each PW-bit column sum to
// ACC_WIDTH and adds it. ARRAY_ACC_SAT_EN selects clamping with a sticky
// sat flag; otherwise accumulation wraps and sat is tied low.
module psum_accum
  import bf_array_pkg::*;
#(
  parameter int unsigned N         = 8,
  parameter int unsigned PW        = COL_WIDTH_DEF * 4,
  parameter int unsigned ACC_WIDTH = ACC_WIDTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   add_en,
  input  logic [N*PW-1:0]        col_psum,
  output logic [N*ACC_WIDTH-1:0] acc,
  output logic                   sat
);

  localparam int unsigned A = ACC_WIDTH;

  logic [N*A-1:0] acc_q, acc_d;
  logic [A-1:0]   ext;

`ifdef ARRAY_ACC_SAT_EN
  logic         sat_q, sat_d;
  logic [A:0]   sum;

  // One extra sum bit exposes signed overflow; clamp toward its true sign.
  always_comb begin
    acc_d = acc_q;
    sat_d = sat_q;
    ext   = '0;
    sum   = '0;
    if (clear) begin
      acc_d = '0;
      sat_d = 1'b0;
    end else if (add_en) begin
      for (int unsigned c = 0; c < N; c++) begin
        ext = A'($signed(col_psum[c*PW +: PW]));
        sum = {acc_q[c*A+A-1], acc_q[c*A +: A]} + {ext[A-1], ext};
        if (sum[A] != sum[A-1]) begin
          acc_d[c*A +: A] = sum[A] ? {1'b1, {(A-1){1'b0}}} : {1'b0, {(A-1){1'b1}}};
          sat_d = 1'b1;
        end else begin
          acc_d[c*A +: A] = sum[A-1:0];
        end
      end
    end
  end

  // Accumulator and sticky saturation registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      sat_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      sat_q <= sat_d;
    end
  end

  assign sat = sat_q;
`else
  // Plain modular accumulation.
  always_comb begin
    acc_d = acc_q;
    ext   = '0;
    if (clear) begin
      acc_d = '0;
    end else if (add_en) begin
      for (int unsigned c = 0; c < N; c++) begin
        ext = A'($signed(col_psum[c*PW +: PW]));
        acc_d[c*A +: A] = acc_q[c*A +: A] + ext;
      end
    end
  end

  // Accumulator registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
  end

  assign sat = 1'b0;
`endif

  assign acc = acc_q;

endmodule

// File: rtl/systolic_array.sv
// Weight-stationary N x N array. Row r multiplies the input vector delayed r
// cycles by its stationary weights and adds into the partial sum handed down
// from row r-1; a final register gives N+1 cycles from vec to psum.
module systolic_array
  import bf_array_pkg::*;
#(
  parameter int unsigned N         = 8,
  parameter int unsigned COL_WIDTH = COL_WIDTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  opw_t                       in_width,
  input  opw_t                       weight_width,
  input  logic                       s_in,
  input  logic                       s_weight,
  input  logic [N*N*8-1:0]           weights,
  input  logic [N*8-1:0]             vec,
  output logic [N*COL_WIDTH*4-1:0]   psum
);

  localparam int unsigned PW = COL_WIDTH * 4;

  logic [N*8-1:0]  skew_q  [N-1];
  logic [N*8-1:0]  skew_d  [N-1];
  logic [N*PW-1:0] stage_q [N];
  logic [N*PW-1:0] stage_d [N];
  logic [N*PW-1:0] psum_q, psum_d;
  logic [N*8-1:0]  row_vec  [N];
  logic [N*PW-1:0] row_base [N];
  logic signed [8:0]  op_a, op_b;
  logic signed [17:0] prod;

  // Per-row operand and incoming partial-sum selection; row 0 starts from zero.
  always_comb begin
    row_vec[0]  = vec;
    row_base[0] = '0;
    skew_d[0]   = vec;
    for (int unsigned r = 1; r < N; r++) begin
      row_vec[r]  = skew_q[r-1];
      row_base[r] = stage_q[r-1];
    end
    for (int unsigned k = 1; k < N - 1; k++) begin
      skew_d[k] = skew_q[k-1];
    end
  end

  // Multiply-accumulate for every cell, products sign-extended to PW.
  always_comb begin
    op_a = '0;
    op_b = '0;
    prod = '0;
    for (int unsigned r = 0; r < N; r++) begin
      stage_d[r] = '0;
      for (int unsigned c = 0; c < N; c++) begin
        op_a = ext_operand(row_vec[r][r*8 +: 8], in_width, s_in);
        op_b = ext_operand(weights[(r*N+c)*8 +: 8], weight_width, s_weight);
        prod = op_a * op_b;
        stage_d[r][c*PW +: PW] = row_base[r][c*PW +: PW] + PW'(prod);
      end
    end
    psum_d = stage_q[N-1];
  end

  // Pipeline registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < N - 1; k++) skew_q[k] <= '0;
      for (int unsigned r = 0; r < N; r++) stage_q[r] <= '0;
      psum_q <= '0;
    end else begin
      for (int unsigned k = 0; k < N - 1; k++) skew_q[k] <= skew_d[k];
      for (int unsigned r = 0; r < N; r++) stage_q[r] <= stage_d[r];
      psum_q <= psum_d;
    end
  end

  assign psum = psum_q;

endmodule

// File: rtl/array_tile_top.sv
// Array tile controller: config -> weight load -> vector stream -> drain ->
// result handshake around systolic_array, with a valid-tag shift register
// aligning accepted vectors to the array output for psum_accum.
// Optional macro ARRAY_ACC_SAT_EN enables saturating accumulation.
module array_tile_top
  import bf_array_pkg::*;
#(
  parameter int unsigned ARRAY_SIZE = 8,
  parameter int unsigned COL_WIDTH  = COL_WIDTH_DEF,
  parameter int unsigned ACC_WIDTH  = ACC_WIDTH_DEF,
  parameter int unsigned PIPE_LAT   = ARRAY_SIZE + 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            cfg_valid,
  output logic                            cfg_ready,
  input  logic [3:0]                      cfg_in_width,
  input  logic [3:0]                      cfg_weight_width,
  input  logic                            cfg_s_in,
  input  logic                            cfg_s_weight,
  input  logic [15:0]                     cfg_num_vec,
  input  logic                            w_valid,
  output logic                            w_ready,
  input  logic [ARRAY_SIZE*ARRAY_SIZE*8-1:0] weights,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [ARRAY_SIZE*8-1:0]         inputs,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [ARRAY_SIZE*ACC_WIDTH-1:0] psum,
  output logic                            sat,
  output logic                            busy
);

  localparam int unsigned N  = ARRAY_SIZE;
  localparam int unsigned PW = COL_WIDTH * 4;

  state_e              state_q, state_d;
  opw_t                in_w_q, in_w_d, w_w_q, w_w_d;
  logic                s_in_q, s_in_d, s_w_q, s_w_d;
  logic [15:0]         num_q, num_d, cnt_q, cnt_d;
  logic [N*N*8-1:0]    w_q, w_d;
  logic [N*8-1:0]      vec_q, vec_d;
  logic                beat_q, beat_d;
  logic [PIPE_LAT-1:0] tag_q, tag_d;
  logic                acc_clear, acc_add, in_fire;
  logic [N*PW-1:0]     col_psum;

  // Next-state, handshakes and register updates. beat_q marks the cycle the
  // registered vector is presented to the array, so the tag leaves the shift
  // register exactly when the array psum for that vector is valid.
  always_comb begin
    state_d   = state_q;
    in_w_d    = in_w_q;
    w_w_d     = w_w_q;
    s_in_d    = s_in_q;
    s_w_d     = s_w_q;
    num_d     = num_q;
    cnt_d     = cnt_q;
    w_d       = w_q;
    vec_d     = vec_q;
    beat_d    = 1'b0;
    tag_d     = {tag_q[PIPE_LAT-2:0], beat_q};
    acc_clear = 1'b0;
    cfg_ready = 1'b0;
    w_ready   = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    in_fire   = 1'b0;
    case (state_q)
      IDLE: begin
        cfg_ready = 1'b1;
        if (cfg_valid) begin
          in_w_d  = cfg_in_width;
          w_w_d   = cfg_weight_width;
          s_in_d  = cfg_s_in;
          s_w_d   = cfg_s_weight;
          num_d   = (cfg_num_vec == 16'd0) ? 16'd1 : cfg_num_vec;
          state_d = LOAD_W;
        end
      end
      LOAD_W: begin
        w_ready = 1'b1;
        if (w_valid) begin
          w_d       = weights;
          acc_clear = 1'b1;
          cnt_d     = '0;
          state_d   = STREAM;
        end
      end
      STREAM: begin
        in_ready = (cnt_q != num_q);
        in_fire  = in_valid && (cnt_q != num_q);
        if (in_fire) begin
          vec_d  = inputs;
          beat_d = 1'b1;
          cnt_d  = cnt_q + 16'd1;
          if (cnt_d == num_q) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!beat_q && tag_q == '0) state_d = OUT;
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy    = (state_q != IDLE);
    acc_add = tag_q[PIPE_LAT-1];
  end

  // Control and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      in_w_q  <= '0;
      w_w_q   <= '0;
      s_in_q  <= 1'b0;
      s_w_q   <= 1'b0;
      num_q   <= '0;
      cnt_q   <= '0;
      w_q     <= '0;
      vec_q   <= '0;
      beat_q  <= 1'b0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      in_w_q  <= in_w_d;
      w_w_q   <= w_w_d;
      s_in_q  <= s_in_d;
      s_w_q   <= s_w_d;
      num_q   <= num_d;
      cnt_q   <= cnt_d;
      w_q     <= w_d;
      vec_q   <= vec_d;
      beat_q  <= beat_d;
      tag_q   <= tag_d;
    end
  end

  systolic_array #(
    .N         (N),
    .COL_WIDTH (COL_WIDTH)
  ) u_array (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_width     (in_w_q),
    .weight_width (w_w_q),
    .s_in         (s_in_q),
    .s_weight     (s_w_q),
    .weights      (w_q),
    .vec          (vec_q),
    .psum         (col_psum)
  );

  psum_accum #(
    .N         (N),
    .PW        (PW),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_accum (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (acc_clear),
    .add_en   (acc_add),
    .col_psum (col_psum),
    .acc      (psum),
    .sat      (sat)
  );

endmodule

// File: tb/tb_array_tile_top.sv
// Directed bench for array_tile_top. Two instances share all inputs: the
// default build, and a narrow one (COL_WIDTH=5, ACC_WIDTH=PW=20) used for the
// overflow case.
module tb_array_tile_top;

  localparam int N        = 8;
  localparam int PIPE_LAT = N + 1;
  localparam int AW       = 64;
  localparam int AWS      = 20;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              cfg_valid, w_valid, in_valid, out_ready;
  logic [3:0]        cfg_in_width, cfg_weight_width;
  logic              cfg_s_in, cfg_s_weight;
  logic [15:0]       cfg_num_vec;
  logic [N*N*8-1:0]  weights;
  logic [N*8-1:0]    inputs;

  logic              cfg_ready, w_ready, in_ready, out_valid, sat, busy;
  logic [N*AW-1:0]   psum;
  logic              cfg_ready_s, w_ready_s, in_ready_s, out_valid_s, sat_s, busy_s;
  logic [N*AWS-1:0]  psum_s;

  int n_assert = 0;
  int n_fail   = 0;

  array_tile_top #(.ARRAY_SIZE(N), .COL_WIDTH(13), .ACC_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_in_width(cfg_in_width), .cfg_weight_width(cfg_weight_width),
    .cfg_s_in(cfg_s_in), .cfg_s_weight(cfg_s_weight), .cfg_num_vec(cfg_num_vec),
    .w_valid(w_valid), .w_ready(w_ready), .weights(weights),
    .in_valid(in_valid), .in_ready(in_ready), .inputs(inputs),
    .out_valid(out_valid), .out_ready(out_ready),
    .psum(psum), .sat(sat), .busy(busy)
  );

  array_tile_top #(.ARRAY_SIZE(N), .COL_WIDTH(5), .ACC_WIDTH(AWS)) dut_s (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready_s),
    .cfg_in_width(cfg_in_width), .cfg_weight_width(cfg_weight_width),
    .cfg_s_in(cfg_s_in), .cfg_s_weight(cfg_s_weight), .cfg_num_vec(cfg_num_vec),
    .w_valid(w_valid), .w_ready(w_ready_s), .weights(weights),
    .in_valid(in_valid), .in_ready(in_ready_s), .inputs(inputs),
    .out_valid(out_valid_s), .out_ready(out_ready),
    .psum(psum_s), .sat(sat_s), .busy(busy_s)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_cols(input string tag, input longint exp [N]);
    for (int c = 0; c < N; c++)
      chk($sformatf("%s_c%0d", tag, c), psum[c*AW +: AW], exp[c]);
  endtask

  function automatic logic [N*8-1:0] vec_all(input logic [7:0] b);
    return {N{b}};
  endfunction

  function automatic logic [N*N*8-1:0] w_all(input logic [7:0] b);
    return {(N*N){b}};
  endfunction

  function automatic logic [N*N*8-1:0] w_colidx();
    logic [N*N*8-1:0] w;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        w[(r*N+c)*8 +: 8] = 8'(c);
    return w;
  endfunction

  task automatic configure(input logic [3:0] iw, input logic [3:0] ww,
                           input logic si, input logic sw, input logic [15:0] nv);
    cfg_in_width = iw; cfg_weight_width = ww;
    cfg_s_in = si; cfg_s_weight = sw; cfg_num_vec = nv;
    cfg_valid = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
    chk("cfg_w_ready", w_ready, 1'b1);
    chk("cfg_ready_low", cfg_ready, 1'b0);
  endtask

  task automatic load_w(input logic [N*N*8-1:0] wv);
    weights = wv;
    w_valid = 1'b1;
    @(negedge clk);
    w_valid = 1'b0;
    chk("w_in_ready", in_ready, 1'b1);
    chk("w_ready_low", w_ready, 1'b0);
  endtask

  task automatic send(input logic [N*8-1:0] v);
    inputs = v;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int cyc);
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    chk("out_valid_timeout", out_valid, 1'b1);
  endtask

  task automatic ack();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("ack_out_valid_low", out_valid, 1'b0);
    chk("ack_cfg_ready", cfg_ready, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int     lat;
    longint exp [N];
    logic   seen;
    logic [63:0] exp_s;
    logic        exp_sat;

    cfg_valid = 0; w_valid = 0; in_valid = 0; out_ready = 0;
    cfg_in_width = 0; cfg_weight_width = 0; cfg_s_in = 0; cfg_s_weight = 0;
    cfg_num_vec = 0; weights = '0; inputs = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_cfg_ready", cfg_ready, 1'b1);
    chk("rst_w_ready", w_ready, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_sat", sat, 1'b0);
    chk("rst_psum", |psum, 1'b0);
    chk("rst_psum_s", |psum_s, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single vector, weights 1, inputs 2: 16 per column, latency PIPE_LAT+2
    configure(4'd8, 4'd8, 1'b1, 1'b1, 16'd1);
    load_w(w_all(8'h01));
    send(vec_all(8'd2));
    wait_out(lat);
    chk("single_latency", 64'(lat), 64'(PIPE_LAT + 2));
    for (int c = 0; c < N; c++) exp[c] = 16;
    chk_cols("single", exp);
    chk("single_sat", sat, 1'b0);
    chk("single_busy", busy, 1'b1);
    ack();

    // 4-bit signed inputs (0x3E -> -2) against column-index weights
    configure(4'd4, 4'd8, 1'b1, 1'b1, 16'd1);
    load_w(w_colidx());
    send(vec_all(8'h3E));
    wait_out(lat);
    for (int c = 0; c < N; c++) exp[c] = -16 * longint'(c);
    chk_cols("narrow_neg", exp);
    ack();

    // Unsigned operands: 255 * 2 * 8
    configure(4'd8, 4'd8, 1'b0, 1'b0, 16'd1);
    load_w(w_all(8'h02));
    send(vec_all(8'hFF));
    wait_out(lat);
    for (int c = 0; c < N; c++) exp[c] = 4080;
    chk_cols("unsigned", exp);
    ack();

    // Four vectors with bubbles between beats: column c = 80*c
    configure(4'd8, 4'd8, 1'b1, 1'b1, 16'd4);
    load_w(w_colidx());
    for (int k = 0; k < 4; k++) begin
      send(vec_all(8'(k + 1)));
      if (k < 3) begin
        chk("bubble_in_ready", in_ready, 1'b1);
        @(negedge clk);
      end
    end
    chk("multi_in_ready_done", in_ready, 1'b0);
    wait_out(lat);
    for (int c = 0; c < N; c++) exp[c] = 80 * longint'(c);
    chk_cols("multi", exp);

    // Hold OUT for 10 cycles with a competing cfg_valid
    cfg_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("hold_psum_c7", psum[7*AW +: AW], 64'd560);
      chk("hold_cfg_ready", cfg_ready, 1'b0);
      chk("hold_out_valid", out_valid, 1'b1);
      @(negedge clk);
    end
    cfg_valid = 1'b0;
    chk_cols("hold_end", exp);
    ack();
    chk("hold_cfg_ignored", w_ready, 1'b0);
    chk("hold_idle_busy", busy, 1'b0);

    // Reset mid-stream after 2 of 5 vectors
    configure(4'd8, 4'd8, 1'b1, 1'b1, 16'd5);
    load_w(w_all(8'h01));
    send(vec_all(8'd3));
    send(vec_all(8'd3));
    repeat (12) @(negedge clk);
    chk("pre_rst_psum_c0", psum[0 +: AW], 64'd48);
    chk("pre_rst_in_ready", in_ready, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_psum", |psum, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_in_ready", in_ready, 1'b0);
    chk("mid_rst_cfg_ready", cfg_ready, 1'b1);
    chk("mid_rst_out_valid", out_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("post_rst_no_out", seen, 1'b0);
    configure(4'd8, 4'd8, 1'b1, 1'b1, 16'd1);
    load_w(w_all(8'h01));
    send(vec_all(8'd5));
    wait_out(lat);
    for (int c = 0; c < N; c++) exp[c] = 40;
    chk_cols("post_rst", exp);
    ack();

    // cfg_num_vec = 0 accepts exactly one vector
    configure(4'd8, 4'd8, 1'b1, 1'b1, 16'd0);
    load_w(w_all(8'h01));
    send(vec_all(8'd1));
    chk("num0_in_ready", in_ready, 1'b0);
    chk("num0_busy", busy, 1'b1);
    inputs = vec_all(8'd1);
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    wait_out(lat);
    for (int c = 0; c < N; c++) exp[c] = 8;
    chk_cols("num0", exp);
    ack();

    // Signed max operands, 8 vectors: overflows the 20-bit accumulator
    configure(4'd8, 4'd8, 1'b1, 1'b1, 16'd8);
    load_w(w_all(8'h7F));
    inputs = vec_all(8'h7F);
    in_valid = 1'b1;
    repeat (8) @(negedge clk);
    in_valid = 1'b0;
    chk("max_in_ready_done", in_ready, 1'b0);
    wait_out(lat);
    for (int c = 0; c < N; c++) exp[c] = 1032256;
    chk_cols("max_wide", exp);
    chk("max_wide_sat", sat, 1'b0);
`ifdef ARRAY_ACC_SAT_EN
    exp_s = 64'h7FFFF;
    exp_sat = 1'b1;
`else
    exp_s = 64'hFC040;
    exp_sat = 1'b0;
`endif
    for (int c = 0; c < N; c++)
      chk($sformatf("max_narrow_c%0d", c), psum_s[c*AWS +: AWS], exp_s);
    chk("max_narrow_sat", sat_s, exp_sat);
    ack();

    // Next tile clears sat on the weight beat
    configure(4'd8, 4'd8, 1'b1, 1'b1, 16'd1);
    load_w(w_all(8'h01));
    chk("sat_cleared", sat_s, 1'b0);
    chk("acc_cleared_s", |psum_s, 1'b0);
    send(vec_all(8'd1));
    wait_out(lat);
    chk("after_sat_narrow_c0", psum_s[0 +: AWS], 64'd8);
    ack();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
